fib_seq_gen: RTL and testbench



---
 rtl/fib_pkg.sv | 19 +
 rtl/fib_step.sv | 20 ++
 rtl/fib_seq_gen.sv | 104 ++++++++++
 tb/tb_fib_seq_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci term generator.
//   fib_state_e : controller states (IDLE, RUN, DONE)
//   FIB_W       : default term width
//   FIB_A0/B0   : seed values for the current and next term
//   FIB_LAST    : largest term for FIB_W = 4, used by checking code
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_e;

  localparam int FIB_W    = 4;
  localparam int FIB_A0   = 0;
  localparam int FIB_B0   = 1;
  localparam int FIB_LAST = 13;

endpackage

// File: rtl/fib_step.sv
// Combinational Fibonacci step.
//   a    : current term (WIDTH bits)
//   b    : next term (WIDTH+1 bits, MSB set means it no longer fits)
//   next : a + b at WIDTH+1 bits
//   last : b has overflowed WIDTH bits, so a is the final representable term
module fib_step
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH:0]   b,
  output logic [WIDTH:0]   next,
  output logic             last
);

  assign next = {1'b0, a} + b;
  assign last = b[WIDTH];

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci term generator with a valid/ready output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, stop, mode   : begin a run, abort a run, 0 = single pass / 1 = wrap
//   out_valid/out_ready : output handshake
//   out_data, term_idx  : current term and its index
//   busy, done          : running, one-cycle end-of-pass pulse
//
// state | meaning
// IDLE  | waiting for start
// RUN   | presenting one term per handshake
// DONE  | single pass finished, done pulse for one cycle
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_W,
  parameter int IDXW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDXW-1:0]  term_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [WIDTH-1:0] A_SEED = WIDTH'(FIB_A0);
  localparam logic [WIDTH:0]   B_SEED = (WIDTH+1)'(FIB_B0);

  logic [1:0]       state;
  logic [WIDTH-1:0] a;
  logic [WIDTH:0]   b;
  logic [IDXW-1:0]  idx;
  logic             mode_q;
  logic [WIDTH:0]   next;
  logic             last;

  fib_step #(.WIDTH(WIDTH)) u_step (
    .a    (a),
    .b    (b),
    .next (next),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a      <= A_SEED;
      b      <= B_SEED;
      idx    <= '0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            a      <= A_SEED;
            b      <= B_SEED;
            idx    <= '0;
            mode_q <= mode;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          // out_valid is high throughout RUN, so out_ready alone marks a transfer
          if (stop) begin
            a     <= A_SEED;
            b     <= B_SEED;
            idx   <= '0;
            state <= S_IDLE;
          end else if (out_ready) begin
            if (!last) begin
              a   <= b[WIDTH-1:0];
              b   <= next;
              idx <= idx + IDXW'(1);
            end else begin
              // reseed on both wrap and end of pass so out_data returns to 0
              a   <= A_SEED;
              b   <= B_SEED;
              idx <= '0;
              if (!mode_q) state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = (state == S_RUN);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign out_data  = a;
  assign term_idx  = idx;

endmodule

// File: tb/tb_fib_seq_gen.sv
module tb_fib_seq_gen;
  import fib_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, mode, out_ready;
  logic       out_valid, busy, done;
  logic [3:0] out_data;
  logic [3:0] term_idx;

  int compared   = 0;
  int mismatched = 0;

  int fib[$];
  int m_run, m_done, m_pos, m_mode;

  always #5 clk = ~clk;

  fib_seq_gen #(.WIDTH(4), .IDXW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .term_idx  (term_idx),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    if (obs != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // detector reference: is the value a Fibonacci number
  function automatic int is_fib(input int v);
    foreach (fib[i]) if (fib[i] == v) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_pos = 0; m_mode = 0;
  endtask

  task automatic model_step(input int s, input int p, input int md, input int r);
    if (m_done != 0) begin
      m_done = 0;
    end else if (m_run == 0) begin
      if (s != 0 && p == 0) begin
        m_run = 1; m_pos = 0; m_mode = md;
      end
    end else if (p != 0) begin
      m_run = 0; m_pos = 0;
    end else if (r != 0) begin
      if (m_pos == fib.size() - 1) begin
        m_pos = 0;
        if (m_mode == 0) begin
          m_run = 0; m_done = 1;
        end
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic compare_all();
    chk("valid", out_valid, m_run);
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    if (m_run != 0) begin
      chk("data", out_data, fib[m_pos]);
      chk("idx", term_idx, m_pos);
      chk("detector", is_fib(out_data), 1);
    end
  endtask

  task automatic cyc(input int s, input int p, input int md, input int r);
    start = s[0]; stop = p[0]; mode = md[0]; out_ready = r[0];
    model_step(s, p, md, r);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    int x, y;
    fib.push_back(0);
    fib.push_back(1);
    forever begin
      x = fib[fib.size()-1] + fib[fib.size()-2];
      if (x >= 16) break;
      fib.push_back(x);
    end

    start = 0; stop = 0; mode = 0; out_ready = 0;
    rst_n = 0;
    model_reset();
    #12;
    compare_all();
    chk("rst_data", out_data, 0);
    chk("rst_idx", term_idx, 0);
    rst_n = 1;

    // single pass, always ready
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 11; i++) cyc(0, 0, 0, 1);

    // backpressure 1,0,0,1
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, (i % 4 == 0 || i % 4 == 3) ? 1 : 0);

    // continuous wrap for 20 cycles, then abort
    cyc(1, 0, 1, 1);
    for (int i = 0; i < 19; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);

    // stop while presenting 5, then restart
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    chk("pre_stop", out_data, 5);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);

    // start and stop together in IDLE
    cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 1);

    // start pulsed mid-run
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);

    // asynchronous reset while presenting 8
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("pre_rst", out_data, 8);
    #3;
    rst_n = 0;
    model_reset();
    #1;
    compare_all();
    chk("arst_data", out_data, 0);
    chk("arst_idx", term_idx, 0);
    @(posedge clk);
    #3;
    rst_n = 1;
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      x = ($urandom_range(0, 7) == 0) ? 1 : 0;
      y = ($urandom_range(0, 15) == 0) ? 1 : 0;
      cyc(x, y, $urandom_range(0, 1), $urandom_range(0, 3) != 0 ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
